// File: rtl/mux_4to1_pkg.sv
// Shared types and select encodings for the registered 4:1 selector.
package mux_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_D0 = 2'b00;
    localparam sel_t SEL_D1 = 2'b01;
    localparam sel_t SEL_D2 = 2'b10;
    localparam sel_t SEL_D3 = 2'b11;

endpackage : mux_pkg

// File: rtl/mux_4to1_if.sv
// Data/select/enable bundle for mux_4to1. The master drives the sources,
// select and enable; the slave (the selector) returns the registered result.
interface mux_4to1_if
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
);

    logic             en;
    logic [WIDTH-1:0] D_0;
    logic [WIDTH-1:0] D_1;
    logic [WIDTH-1:0] D_2;
    logic [WIDTH-1:0] D_3;
    sel_t             select;
    logic [WIDTH-1:0] D_out;
    logic             out_valid;

    modport master (
        output en,
        output D_0,
        output D_1,
        output D_2,
        output D_3,
        output select,
        input  D_out,
        input  out_valid
    );

    modport slave (
        input  en,
        input  D_0,
        input  D_1,
        input  D_2,
        input  D_3,
        input  select,
        output D_out,
        output out_valid
    );

endinterface : mux_4to1_if

// File: rtl/mux_4to1_comb.sv
// Pure combinational 4:1 selection of WIDTH-bit sources.
module mux_4to1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  sel_t             select_i,
    input  logic [WIDTH-1:0] d_0_i,
    input  logic [WIDTH-1:0] d_1_i,
    input  logic [WIDTH-1:0] d_2_i,
    input  logic [WIDTH-1:0] d_3_i,
    output logic [WIDTH-1:0] d_o
);

    // Full decode; the default arm falls back to source 0 for unknown selects.
    always_comb begin
        d_o = d_0_i;
        case (select_i)
            SEL_D0:  d_o = d_0_i;
            SEL_D1:  d_o = d_1_i;
            SEL_D2:  d_o = d_2_i;
            SEL_D3:  d_o = d_3_i;
            default: d_o = d_0_i;
        endcase
    end

endmodule : mux_4to1_comb

// File: rtl/mux_4to1.sv
// Registered 4:1 selector: one cycle from sampled select/data to D_out,
// out_valid flags the cycle after each capture. Synchronous active-high reset.
module mux_4to1
    import mux_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst,
    mux_4to1_if.slave    bus
);

    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] d_out_d;
    logic [WIDTH-1:0] d_out_q;
    logic             out_valid_d;
    logic             out_valid_q;

    mux_4to1_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .select_i (bus.select),
        .d_0_i    (bus.D_0),
        .d_1_i    (bus.D_1),
        .d_2_i    (bus.D_2),
        .d_3_i    (bus.D_3),
        .d_o      (sel_data)
    );

    // Capture the selected source when enabled, otherwise hold; valid only follows a capture.
    always_comb begin
        d_out_d     = d_out_q;
        out_valid_d = 1'b0;
        if (bus.en) begin
            d_out_d     = sel_data;
            out_valid_d = 1'b1;
        end
    end

    // Output registers; reset wins over enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_out_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            d_out_q     <= d_out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.D_out     = d_out_q;
    assign bus.out_valid = out_valid_q;

endmodule : mux_4to1

// File: tb/tb_mux_4to1.sv
// Scoreboard bench for mux_4to1: an 8-bit and a 1-bit instance share stimulus
// (the 1-bit one sees bit 0 of each source). Each driven cycle pushes the
// expected result for its edge; a monitor pops and compares after each edge.
module tb_mux_4to1;
    import mux_pkg::*;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_s    = 1'b1;
    logic       en_s     = 1'b0;
    sel_t       sel_s    = SEL_D0;
    logic [7:0] d0_s     = 8'h00;
    logic [7:0] d1_s     = 8'h00;
    logic [7:0] d2_s     = 8'h00;
    logic [7:0] d3_s     = 8'h00;
    logic       tog_mode = 1'b0;
    logic       tog_go   = 1'b0;
    logic [7:0] tog0, tog1, tog2, tog3;
    time        ts;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    mux_4to1_if #(.WIDTH(8)) bus8();
    mux_4to1_if #(.WIDTH(1)) bus1();

    assign bus8.en     = en_s;
    assign bus8.select = sel_s;
    assign bus8.D_0    = tog_mode ? tog0 : d0_s;
    assign bus8.D_1    = tog_mode ? tog1 : d1_s;
    assign bus8.D_2    = tog_mode ? tog2 : d2_s;
    assign bus8.D_3    = tog_mode ? tog3 : d3_s;

    assign bus1.en     = en_s;
    assign bus1.select = sel_s;
    assign bus1.D_0    = bus8.D_0[0];
    assign bus1.D_1    = bus8.D_1[0];
    assign bus1.D_2    = bus8.D_2[0];
    assign bus1.D_3    = bus8.D_3[0];

    mux_4to1 #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst_s), .bus(bus8));
    mux_4to1 #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst_s), .bus(bus1));

    // Free-running toggles; they start 2 units after a falling edge so they
    // never coincide with a rising edge (half periods 10/15/20/25).
    initial begin tog0 = 8'h0F; @(posedge tog_go); while (tog_go) begin #10; if (tog_go) tog0 = ~tog0; end end
    initial begin tog1 = 8'h5A; @(posedge tog_go); while (tog_go) begin #15; if (tog_go) tog1 = ~tog1; end end
    initial begin tog2 = 8'hC3; @(posedge tog_go); while (tog_go) begin #20; if (tog_go) tog2 = ~tog2; end end
    initial begin tog3 = 8'h96; @(posedge tog_go); while (tog_go) begin #25; if (tog_go) tog3 = ~tog3; end end

    function automatic logic [7:0] d1_at(input time t);
        time n;
        n = (t - ts) / 15;
        return n[0] ? 8'hA5 : 8'h5A;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic e, input sel_t s,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d,
                         input logic ev, input logic [7:0] ed);
        @(negedge clk);
        tog_go   = 1'b0;
        tog_mode = 1'b0;
        rst_s    = r;
        en_s     = e;
        sel_s    = s;
        d0_s     = a;
        d1_s     = b;
        d2_s     = c;
        d3_s     = d;
        q.push_back(exp_t'{v: ev, d: ed});
    endtask

    // Monitor: one expected entry per rising edge, compared 1 unit after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("valid_w8", {7'd0, bus8.out_valid}, {7'd0, e.v});
                check("dout_w8",  bus8.D_out,             e.d);
                check("valid_w1", {7'd0, bus1.out_valid}, {7'd0, e.v});
                check("dout_w1",  {7'd0, bus1.D_out},     {7'd0, e.d[0]});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached, queue depth %0d expected 0", q.size());
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held two cycles with en=1
        apply(1, 1, SEL_D0, 8'h01, 8'h01, 8'h00, 8'h01, 0, 8'h00);
        apply(1, 1, SEL_D3, 8'h01, 8'h01, 8'h00, 8'h01, 0, 8'h00);
        // Select sweep
        apply(0, 1, SEL_D0, 8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01);
        apply(0, 1, SEL_D1, 8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01);
        apply(0, 1, SEL_D2, 8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h00);
        apply(0, 1, SEL_D3, 8'h01, 8'h01, 8'h00, 8'h01, 1, 8'h01);
        apply(0, 1, SEL_D3, 8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h44);
        apply(0, 1, SEL_D2, 8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h33);
        apply(0, 1, SEL_D1, 8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h22);
        apply(0, 1, SEL_D0, 8'h11, 8'h22, 8'h33, 8'h44, 1, 8'h11);

        // Toggling sources, select held at 01 for 20 cycles
        @(negedge clk);
        tog_mode = 1'b1;
        rst_s    = 1'b0;
        en_s     = 1'b1;
        sel_s    = SEL_D1;
        q.push_back(exp_t'{v: 1'b1, d: 8'h5A});
        #2;
        ts     = $time;
        tog_go = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            q.push_back(exp_t'{v: 1'b1, d: d1_at($time + 5)});
        end

        // Hold with changing source
        apply(0, 1, SEL_D2, 8'h00, 8'h00, 8'hA5, 8'h00, 1, 8'hA5);
        apply(0, 0, SEL_D2, 8'h00, 8'h00, 8'h3C, 8'h00, 0, 8'hA5);
        apply(0, 0, SEL_D2, 8'h00, 8'h00, 8'h3C, 8'h00, 0, 8'hA5);
        apply(0, 0, SEL_D2, 8'h00, 8'h00, 8'h3C, 8'h00, 0, 8'hA5);
        apply(0, 1, SEL_D2, 8'h00, 8'h00, 8'h3C, 8'h00, 1, 8'h3C);

        // Reset priority over enable, then reset mid-stream and recovery
        apply(1, 1, SEL_D3, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 8'h00);
        apply(0, 1, SEL_D3, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 8'hFF);
        apply(1, 0, SEL_D3, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 8'h00);
        apply(0, 0, SEL_D3, 8'h00, 8'h00, 8'h00, 8'hFF, 0, 8'h00);
        apply(0, 1, SEL_D3, 8'h00, 8'h00, 8'h00, 8'hFF, 1, 8'hFF);

        // Same-edge select and data change
        apply(0, 1, SEL_D0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h00);
        apply(0, 1, SEL_D3, 8'h00, 8'h00, 8'h00, 8'h01, 1, 8'h01);

        // Reset pulse between edges must not disturb the next capture
        apply(0, 1, SEL_D0, 8'h5A, 8'h00, 8'h00, 8'h01, 1, 8'h5A);
        #2 rst_s = 1'b1;
        #2 rst_s = 1'b0;
        apply(0, 0, SEL_D1, 8'h00, 8'hFF, 8'h00, 8'h00, 0, 8'h5A);

        @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: queue depth %0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux_4to1

// File: doc/mux_4to1.md
Name: mux_4to1

Overview:
- Registered 4-to-1 data selector.
- Each clock cycle, one of four equal-width data inputs is chosen by a 2-bit select and presented on a registered output with one cycle of latency.
- Used as a generic leaf datapath element wherever a clean, glitch-free, clock-aligned selection of four sources is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of D_out (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- en  input  1  capture enable; when high, the selected input is loaded into D_out.
- D_0  input  WIDTH  data source 0.
- D_1  input  WIDTH  data source 1.
- D_2  input  WIDTH  data source 2.
- D_3  input  WIDTH  data source 3.
- select  input  2  source index: 00→D_0, 01→D_1, 10→D_2, 11→D_3.
- D_out  output  WIDTH  registered selected data.
- out_valid  output  1  high in the cycle after a capture (en was high at the previous edge).

Interface decision (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Behaviour:
- Reset: at a rising edge with rst=1, D_out ← all zeros and out_valid ← 0.
  - rst has priority over en.
  - No asynchronous path exists; asserting rst between edges has no effect until the next edge.
- Capture: at a rising edge with rst=0 and en=1, D_out ← input indexed by select as sampled at that edge, and out_valid ← 1.
- Hold: at a rising edge with rst=0 and en=0, D_out holds its previous value and out_valid ← 0.
- Latency: exactly one cycle from the sampled inputs/select to D_out. There is no combinational path from any input to D_out or out_valid.
- Select is a full decode with no don't-care states.
- X/Z on select: simulation may propagate X. Synthesis uses a parallel case with a default arm of D_0.
- Input changes between edges, including data toggling and select changes, are invisible to the output until the next capture edge.
- Simultaneous select change and data change: both are sampled at the same edge, and the new select picks the new data.
- Reset mid-stream: the output clears at that edge. The first post-reset capture occurs at the first edge with rst=0 and en=1.
- Width rule: all data ports are exactly WIDTH bits. There is no truncation or extension.

Decomposition:
- Shared package mux_pkg:
  - typedef sel_t = logic[1:0].
  - Constants SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10, SEL_D3=2'b11.
- One natural sub-module, mux_4to1_comb: the pure combinational 4:1 selection on WIDTH bits.
- The top level wraps mux_4to1_comb with the enable/reset output register and the out_valid flop.

Test Plan:
- Reset: hold rst=1 for 2 cycles with D_0..D_3 = 1,1,0,1 and en=1 → D_out=0 and out_valid=0 during reset and at the first edge after rst is asserted.
- Select sweep: WIDTH=1, en=1, D_0=1, D_1=1, D_2=0, D_3=1; select = 00, 01, 10, 11, one per cycle → D_out = 1, 1, 0, 1 on the following cycles; out_valid=1 throughout.
- Toggling data: each D_i toggles at a distinct period (20/30/40/50 time units); select held at 01 for 200 time units → D_out equals the D_1 value sampled at each preceding rising clk edge.
- Hold: WIDTH=8, select=10, D_2=8'hA5, capture, then en=0 and D_2=8'h3C for 3 cycles → D_out stays 8'hA5 and out_valid=0. Then en=1 → D_out=8'h3C.
- Reset priority: rst=1 and en=1 at the same edge with select=11, D_3=8'hFF → D_out=8'h00 and out_valid=0.
- Same-edge select/data change: select 00→11 and D_3 0→1 at the same edge, en=1 → D_out=1 one cycle later.
